// File: rtl/exec_stage_pipe.sv
// exec_stage_pipe
// Registered execute stage. Takes one decoded instruction per cycle over a
// valid/ready handshake and produces ALU, compare, branch, load/store address
// and multiply results in an output register toward the memory stage. Owns
// the NZCV flags register. MUL runs on a radix-2 shift-add unit over DATA_W
// iterations; every other kind completes in one cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop in-flight work (output register and multiplier)
//   in_valid/in_ready input handshake
//   op_kind, aluop, cond, rd, src1, src2, rd_val, imm, use_imm, mem
//                     decoded instruction fields
//   out_valid/out_ready output handshake
//   out_kind, out_rd, out_result, out_store_data, out_addr, out_taken
//                     registered results
//   flags_q           architectural NZCV flags {N,Z,C,V}
module exec_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 18,
  parameter int MEM_W  = 22,
  parameter int MUL_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_kind,
  input  logic [4:0]        aluop,
  input  logic [3:0]        cond,
  input  logic [3:0]        rd,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [DATA_W-1:0] rd_val,
  input  logic [IMM_W-1:0]  imm,
  input  logic              use_imm,
  input  logic [MEM_W-1:0]  mem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_kind,
  output logic [3:0]        out_rd,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [DATA_W-1:0] out_addr,
  output logic              out_taken,
  output logic [3:0]        flags_q
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = SH_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  localparam logic [2:0] K_ALU = 3'd0;
  localparam logic [2:0] K_CMP = 3'd1;
  localparam logic [2:0] K_JMP = 3'd2;
  localparam logic [2:0] K_LD  = 3'd3;
  localparam logic [2:0] K_STR = 3'd4;
  localparam logic [2:0] K_MUL = 3'd5;

  typedef enum logic [0:0] {S_IDLE, S_MUL_BUSY} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  mcand_q;
  logic [DATA_W-1:0]  mplier_q;
  logic [DATA_W-1:0]  acc_q;
  logic [3:0]         mul_rd_q;

  logic [DATA_W-1:0]  imm_sext;
  logic [DATA_W-1:0]  mem_sext;
  logic [DATA_W-1:0]  op2;
  logic [DATA_W-1:0]  alu_res;
  logic [DATA_W-1:0]  cmp_diff;
  logic [3:0]         cmp_flags;
  logic               jmp_taken;
  logic [SH_W-1:0]    shamt;
  logic               big_shift;
  logic               out_free;
  logic               accept;
  logic               mul_start;
  logic [DATA_W-1:0]  acc_d;

  logic [DATA_W-1:0]  result_d;
  logic [DATA_W-1:0]  store_d;
  logic [DATA_W-1:0]  addr_d;
  logic               taken_d;

  assign imm_sext = DATA_W'($signed(imm));
  assign mem_sext = DATA_W'($signed(mem));
  assign op2      = use_imm ? imm_sext : src2;

  assign out_free  = !out_valid || out_ready;
  assign in_ready  = (state_q == S_IDLE) && out_free && !flush && !rst;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op_kind == K_MUL) && (MUL_EN != 0);

  // DATA_W is a power of two, so op2 >= DATA_W exactly when any bit above
  // the shift-index field is set.
  assign shamt     = op2[SH_W-1:0];
  assign big_shift = |op2[DATA_W-1:SH_W];

  always_comb begin
    alu_res = '0;
    case (aluop)
      5'd0: alu_res = src1 + op2;
      5'd1: alu_res = src1 - op2;
      5'd2: alu_res = src1 & op2;
      5'd3: alu_res = src1 | op2;
      5'd4: alu_res = src1 ^ op2;
      5'd5: alu_res = ~(use_imm ? imm_sext : src1);
      5'd6: alu_res = big_shift ? '0 : (src1 << shamt);
      5'd7: alu_res = big_shift ? '0 : (src1 >> shamt);
      5'd8: alu_res = big_shift ? {DATA_W{src1[DATA_W-1]}}
                                : DATA_W'($signed(src1) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Compare flags: C is "no borrow", V is signed overflow of src1 - op2.
  assign cmp_diff  = src1 - op2;
  assign cmp_flags = {cmp_diff[DATA_W-1],
                      (cmp_diff == '0),
                      (src1 >= op2),
                      (src1[DATA_W-1] != op2[DATA_W-1]) &&
                      (cmp_diff[DATA_W-1] != src1[DATA_W-1])};

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    jmp_taken = 1'b0;
    case (cond)
      4'd0:  jmp_taken = z;
      4'd1:  jmp_taken = !z;
      4'd2:  jmp_taken = c;
      4'd3:  jmp_taken = !c;
      4'd4:  jmp_taken = n;
      4'd5:  jmp_taken = !n;
      4'd6:  jmp_taken = v;
      4'd7:  jmp_taken = !v;
      4'd8:  jmp_taken = c && !z;
      4'd9:  jmp_taken = !(c && !z);
      4'd10: jmp_taken = (n == v);
      4'd11: jmp_taken = (n != v);
      4'd12: jmp_taken = !z && (n == v);
      4'd13: jmp_taken = !(!z && (n == v));
      4'd14: jmp_taken = 1'b1;
      default: jmp_taken = 1'b0;
    endcase
  end

  // Output fields for the single-cycle kinds; with MUL_EN=0 a MUL falls
  // through here and produces a zero result.
  always_comb begin
    result_d = '0;
    store_d  = '0;
    addr_d   = '0;
    taken_d  = 1'b0;
    case (op_kind)
      K_ALU: result_d = alu_res;
      K_JMP: begin
        addr_d  = mem_sext;
        taken_d = jmp_taken;
      end
      K_LD:  addr_d = mem_sext;
      K_STR: begin
        addr_d  = mem_sext;
        store_d = rd_val;
      end
      default: ;
    endcase
  end

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      acc_q          <= '0;
      mul_rd_q       <= '0;
      out_valid      <= 1'b0;
      out_kind       <= '0;
      out_rd         <= '0;
      out_result     <= '0;
      out_store_data <= '0;
      out_addr       <= '0;
      out_taken      <= 1'b0;
      flags_q        <= '0;
    end else if (flush) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      // A pop frees the register; a load below on the same edge overrides.
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mul_start) begin
            state_q  <= S_MUL_BUSY;
            cnt_q    <= '0;
            mcand_q  <= src1;
            mplier_q <= op2;
            acc_q    <= '0;
            mul_rd_q <= rd;
          end else if (accept) begin
            out_valid      <= 1'b1;
            out_kind       <= op_kind;
            out_rd         <= rd;
            out_result     <= result_d;
            out_store_data <= store_d;
            out_addr       <= addr_d;
            out_taken      <= taken_d;
            if (op_kind == K_CMP) flags_q <= cmp_flags;
          end
        end
        S_MUL_BUSY: begin
          if (cnt_q != CNT_LAST) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
          end else if (out_free) begin
            // Product ready; if the output is still occupied we simply wait.
            state_q        <= S_IDLE;
            out_valid      <= 1'b1;
            out_kind       <= K_MUL;
            out_rd         <= mul_rd_q;
            out_result     <= acc_q;
            out_store_data <= '0;
            out_addr       <= '0;
            out_taken      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage_pipe.sv
module tb_exec_stage_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [2:0]  op_kind;
  logic [4:0]  aluop;
  logic [3:0]  cond, rd;
  logic [31:0] src1, src2, rd_val;
  logic [17:0] imm;
  logic        use_imm;
  logic [21:0] mem;
  logic        out_valid, out_ready;
  logic [2:0]  out_kind;
  logic [3:0]  out_rd;
  logic [31:0] out_result, out_store_data, out_addr;
  logic        out_taken;
  logic [3:0]  flags_q;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  kind;
    logic [3:0]  rd;
    logic [31:0] result;
    logic [31:0] store;
    logic [31:0] addr;
    logic        taken;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] mflags;

  exec_stage_pipe #(.DATA_W(32), .IMM_W(18), .MEM_W(22), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op_kind(op_kind), .aluop(aluop), .cond(cond), .rd(rd), .src1(src1), .src2(src2),
    .rd_val(rd_val), .imm(imm), .use_imm(use_imm), .mem(mem), .out_valid(out_valid),
    .out_ready(out_ready), .out_kind(out_kind), .out_rd(out_rd), .out_result(out_result),
    .out_store_data(out_store_data), .out_addr(out_addr), .out_taken(out_taken),
    .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] sx(input int value, input int bits);
    int v;
    v = value;
    if (v >= (1 << (bits - 1))) v = v - (1 << bits);
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_alu(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] notsrc);
    logic [63:0] w;
    longint      sa;
    int          amt;
    amt = (b > 32'd63) ? 63 : int'(b);
    case (op)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a & b;
      5'd3: return a | b;
      5'd4: return a ^ b;
      5'd5: return ~notsrc;
      5'd6: begin w = {32'b0, a} << amt; return w[31:0]; end
      5'd7: begin w = {32'b0, a} >> amt; return w[31:0]; end
      5'd8: begin sa = longint'($signed(a)); sa = sa >>> amt; return 32'(sa); end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] m_flags(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    longint      sd;
    logic        v;
    d  = a - b;
    sd = longint'($signed(a)) - longint'($signed(b));
    v  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {d[31], d == 32'd0, {32'b0, a} >= {32'b0, b}, v};
  endfunction

  function automatic logic m_taken(input logic [3:0] c, input logic [3:0] fl);
    logic n, z, cy, v;
    {n, z, cy, v} = fl;
    case (c)
      4'd0: return z;             4'd1: return !z;
      4'd2: return cy;            4'd3: return !cy;
      4'd4: return n;             4'd5: return !n;
      4'd6: return v;             4'd7: return !v;
      4'd8: return cy && !z;      4'd9: return !cy || z;
      4'd10: return n == v;       4'd11: return n != v;
      4'd12: return !z && n == v; 4'd13: return z || n != v;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input logic [2:0] k, input logic [4:0] aop,
                                 input logic [3:0] c, input logic [3:0] r,
                                 input logic [31:0] a, input logic [31:0] s2,
                                 input logic [31:0] rv, input logic [17:0] im,
                                 input logic ui, input logic [21:0] m,
                                 input logic [3:0] fl);
    exp_t        e;
    logic [31:0] b;
    logic [63:0] p;
    b = ui ? sx(int'(im), 18) : s2;
    e = '0;
    e.kind = k;
    e.rd   = r;
    case (k)
      3'd0: e.result = m_alu(aop, a, b, ui ? sx(int'(im), 18) : a);
      3'd2: begin e.addr = sx(int'(m), 22); e.taken = m_taken(c, fl); end
      3'd3: e.addr = sx(int'(m), 22);
      3'd4: begin e.addr = sx(int'(m), 22); e.store = rv; end
      3'd5: begin p = {32'b0, a} * {32'b0, b}; e.result = p[31:0]; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] k, input logic [4:0] aop, input logic [3:0] c,
                       input logic [3:0] r, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] rv, input logic [17:0] im, input logic ui,
                       input logic [21:0] m);
    op_kind = k; aluop = aop; cond = c; rd = r; src1 = a; src2 = b;
    rd_val = rv; imm = im; use_imm = ui; mem = m; in_valid = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({out_valid, out_kind, out_rd, out_result, out_store_data, out_addr, out_taken} !== '0) begin
      errors++; $display("FAIL reset_outputs got valid=%b result=%h addr=%h exp all 0", out_valid, out_result, out_addr);
    end
    checks++;
    if (flags_q !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", flags_q); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    $display("txn reset done");
  endtask

  task automatic test_alu();
    logic [4:0]  d_op  [5] = '{5'd0, 5'd1, 5'd6, 5'd8, 5'd20};
    logic [31:0] d_a   [5] = '{32'd5, 32'd3, 32'd1, 32'h8000_0000, 32'h1234};
    logic [31:0] d_b   [5] = '{32'd7, 32'd5, 32'd32, 32'd40, 32'd3};
    logic [31:0] d_exp [5] = '{32'd12, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd0};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      drive(3'd0, d_op[i], 4'd0, 4'(i), d_a[i], d_b[i], 32'd0, 18'd0, 1'b0, 22'd0);
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_result !== d_exp[i] || out_kind !== 3'd0) begin
        errors++;
        $display("FAIL alu_directed[%0d] got valid=%b result=%h kind=%0d exp 1 %h 0",
                 i, out_valid, out_result, out_kind, d_exp[i]);
      end
      $display("txn alu op=%0d a=%h b=%h -> %h", d_op[i], d_a[i], d_b[i], out_result);
    end
    for (int i = 0; i < 40; i++) begin
      logic [4:0]  aop;
      logic [31:0] a, b;
      logic [17:0] im;
      logic        ui;
      aop = 5'($urandom_range(0, 12));
      a = pick32(); b = pick32(); im = 18'($urandom); ui = 1'($urandom);
      if (ui && aop >= 5'd6 && aop <= 5'd8) im = 18'($urandom_range(0, 40));
      e = model(3'd0, aop, 4'd0, 4'($urandom), a, b, 32'd0, im, ui, 22'd0, 4'd0);
      drive(3'd0, aop, 4'd0, e.rd, a, b, 32'd0, im, ui, 22'd0);
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_result !== e.result || out_rd !== e.rd) begin
        errors++;
        $display("FAIL alu_random op=%0d a=%h b=%h imm=%h ui=%b got %h rd=%0d exp %h rd=%0d",
                 aop, a, b, im, ui, out_result, out_rd, e.result, e.rd);
      end
      $display("txn alu op=%0d a=%h b=%h ui=%b -> %h", aop, a, b, ui, out_result);
    end
    tick();
  endtask

  task automatic test_cmp_jmp();
    drive(3'd1, 5'd0, 4'd0, 4'd0, 32'd3, 32'd0, 32'd0, 18'd5, 1'b1, 22'd0);
    tick();
    checks++;
    if (flags_q !== 4'b1000 || out_valid !== 1'b1 || out_result !== 32'd0 || out_kind !== 3'd1) begin
      errors++;
      $display("FAIL cmp_3_5 got flags=%b valid=%b result=%h kind=%0d exp 1000 1 0 1",
               flags_q, out_valid, out_result, out_kind);
    end
    drive(3'd2, 5'd0, 4'd11, 4'd0, 32'd0, 32'd0, 32'd0, 18'd0, 1'b0, 22'h3F_FFFC);
    tick();
    checks++;
    if (out_taken !== 1'b1 || out_addr !== 32'hFFFF_FFFC || out_kind !== 3'd2) begin
      errors++;
      $display("FAIL jmp_lt got taken=%b addr=%h kind=%0d exp 1 fffffffc 2", out_taken, out_addr, out_kind);
    end
    drive(3'd2, 5'd0, 4'd10, 4'd0, 32'd0, 32'd0, 32'd0, 18'd0, 1'b0, 22'h3F_FFFC);
    tick();
    checks++;
    if (out_taken !== 1'b0) begin errors++; $display("FAIL jmp_ge got taken=%b exp 0", out_taken); end
    $display("txn cmp 3,5 then jmp LT/GE");
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      logic [3:0]  c, fl;
      logic [21:0] m;
      a = pick32(); b = ($urandom_range(0, 3) == 0) ? a : pick32();
      c = 4'($urandom); m = 22'($urandom);
      fl = m_flags(a, b);
      drive(3'd1, 5'd0, 4'd0, 4'd0, a, b, 32'd0, 18'd0, 1'b0, 22'd0);
      tick();
      checks++;
      if (flags_q !== fl) begin
        errors++; $display("FAIL cmp_random a=%h b=%h got %b exp %b", a, b, flags_q, fl);
      end
      drive(3'd2, 5'd0, c, 4'd0, 32'd0, 32'd0, 32'd0, 18'd0, 1'b0, m);
      tick();
      checks++;
      if (out_taken !== m_taken(c, fl) || out_addr !== sx(int'(m), 22)) begin
        errors++;
        $display("FAIL jmp_random cond=%0d flags=%b got taken=%b addr=%h exp %b %h",
                 c, fl, out_taken, out_addr, m_taken(c, fl), sx(int'(m), 22));
      end
      $display("txn cmp a=%h b=%h flags=%b jmp cond=%0d taken=%b", a, b, flags_q, c, out_taken);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_mul();
    logic [31:0] m_a [2] = '{32'h0001_0001, 32'h8000_0000};
    logic [31:0] m_b [2] = '{32'h0000_FFFF, 32'd2};
    logic [31:0] m_e [2] = '{32'hFFFF_FFFF, 32'd0};
    for (int i = 0; i < 2; i++) begin
      drive(3'd5, 5'd0, 4'd0, 4'd9, m_a[i], m_b[i], 32'd0, 18'd0, 1'b0, 22'd0);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_accept_ready got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 33; k++) begin
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL mul_busy[%0d] cycle %0d got valid=%b in_ready=%b exp 0 0", i, k, out_valid, in_ready);
        end
        tick();
      end
      checks++;
      if (out_valid !== 1'b1 || out_result !== m_e[i] || out_kind !== 3'd5 || out_rd !== 4'd9) begin
        errors++;
        $display("FAIL mul_result[%0d] got valid=%b result=%h kind=%0d rd=%0d exp 1 %h 5 9",
                 i, out_valid, out_result, out_kind, out_rd, m_e[i]);
      end
      $display("txn mul %h * %h -> %h", m_a[i], m_b[i], out_result);
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    out_ready = 1'b0;
    drive(3'd0, 5'd0, 4'd0, 4'd1, 32'd100, 32'd23, 32'd0, 18'd0, 1'b0, 22'd0);
    tick();
    in_valid = 1'b0;
    held = 32'd123;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== held || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got valid=%b result=%h in_ready=%b exp 1 %h 0",
                 k, out_valid, out_result, in_ready, held);
      end
      tick();
    end
    $display("txn stall held %h for 10 cycles", out_result);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      drive(3'd0, 5'd0, 4'd0, 4'(k), a, b, 32'd0, 18'd0, 1'b0, 22'd0);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", k, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_result !== a + b || out_rd !== 4'(k)) begin
        errors++;
        $display("FAIL b2b_result[%0d] got valid=%b result=%h exp 1 %h", k, out_valid, out_result, a + b);
      end
      $display("txn b2b add %h+%h -> %h", a, b, out_result);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    drive(3'd1, 5'd0, 4'd0, 4'd0, 32'd3, 32'd5, 32'd0, 18'd0, 1'b0, 22'd0);
    tick();
    drive(3'd5, 5'd0, 4'd0, 4'd2, 32'd7, 32'd9, 32'd0, 18'd0, 1'b0, 22'd0);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    flush = 1'b1;
    drive(3'd0, 5'd0, 4'd0, 4'd0, 32'd1, 32'd1, 32'd0, 18'd0, 1'b0, 22'd0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || flags_q !== 4'b1000) begin
      errors++;
      $display("FAIL flush_after got valid=%b in_ready=%b flags=%b exp 0 1 1000", out_valid, in_ready, flags_q);
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_mul_aborted cycle %0d got valid=%b exp 0", k, out_valid); end
    end
    out_ready = 1'b0;
    drive(3'd0, 5'd0, 4'd0, 4'd0, 32'd4, 32'd4, 32'd0, 18'd0, 1'b0, 22'd0);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_held_result got valid=%b exp 0", out_valid); end
    out_ready = 1'b1;
    $display("txn flush mid-mul and on held result");
    tick();
  endtask

  task automatic test_reset_mid_mul();
    drive(3'd1, 5'd0, 4'd0, 4'd0, 32'd3, 32'd5, 32'd0, 18'd0, 1'b0, 22'd0);
    tick();
    drive(3'd5, 5'd0, 4'd0, 4'd3, 32'd11, 32'd13, 32'd0, 18'd0, 1'b0, 22'd0);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    tick();
    checks++;
    if ({out_valid, out_kind, out_rd, out_result, out_store_data, out_addr, out_taken, flags_q} !== '0) begin
      errors++;
      $display("FAIL rst_mid_mul got valid=%b result=%h flags=%b exp all 0", out_valid, out_result, flags_q);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mul_aborted cycle %0d got %b exp 0", k, out_valid); end
    end
    $display("txn reset mid-mul");
  endtask

  task automatic pop_compare();
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL rand_unexpected_output got kind=%0d result=%h exp no output", out_kind, out_result);
    end else begin
      e = sb_q.pop_front();
      if (out_kind !== e.kind || out_rd !== e.rd || out_result !== e.result ||
          out_store_data !== e.store || out_addr !== e.addr || out_taken !== e.taken) begin
        errors++;
        $display("FAIL rand_output got k=%0d rd=%0d r=%h s=%h a=%h t=%b exp k=%0d rd=%0d r=%h s=%h a=%h t=%b",
                 out_kind, out_rd, out_result, out_store_data, out_addr, out_taken,
                 e.kind, e.rd, e.result, e.store, e.addr, e.taken);
      end
      $display("txn out kind=%0d rd=%0d result=%h store=%h addr=%h taken=%b",
               out_kind, out_rd, out_result, out_store_data, out_addr, out_taken);
    end
  endtask

  task automatic test_random();
    logic        hold_prev;
    logic [109:0] snap, now;
    mflags = 4'b0;
    hold_prev = 1'b0;
    snap = '0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      now = {out_valid, out_kind, out_rd, out_result, out_store_data, out_addr, out_taken};
      checks++;
      if (flags_q !== mflags) begin errors++; $display("FAIL rand_flags cycle %0d got %b exp %b", cyc, flags_q, mflags); end
      if (hold_prev) begin
        checks++;
        if (now !== snap) begin errors++; $display("FAIL rand_stall_stable cycle %0d got %h exp %h", cyc, now, snap); end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 6) begin
        logic [2:0] k;
        logic [4:0] aop;
        k = 3'($urandom_range(0, 7));
        if (k == 3'd5 && $urandom_range(0, 3) != 0) k = 3'd0;
        aop = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 9));
        drive(k, aop, 4'($urandom), 4'($urandom), pick32(), pick32(), $urandom,
              18'($urandom), 1'($urandom), 22'($urandom));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rand_ready_under_stall cycle %0d got %b exp 0", cyc, in_ready); end
      end
      if (out_valid && out_ready) pop_compare();
      hold_prev = out_valid && !out_ready;
      snap = {out_valid, out_kind, out_rd, out_result, out_store_data, out_addr, out_taken};
      if (in_valid && in_ready) begin
        sb_q.push_back(model(op_kind, aluop, cond, rd, src1, src2, rd_val, imm, use_imm, mem, mflags));
        if (op_kind == 3'd1) mflags = m_flags(src1, use_imm ? sx(int'(imm), 18) : src2);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && sb_q.size() > 0; k++) begin
      #1;
      if (out_valid) pop_compare();
      tick();
    end
    checks++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain got pending=%0d valid=%b exp 0 0", sb_q.size(), out_valid);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_kind = '0; aluop = '0; cond = '0; rd = '0; src1 = '0; src2 = '0;
    rd_val = '0; imm = '0; use_imm = 1'b0; mem = '0; mflags = '0;
    test_reset();
    test_alu();
    test_cmp_jmp();
    test_mul();
    test_backpressure();
    test_flush();
    test_reset_mid_mul();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule
